// File: rtl/regfile_write_arbiter.sv
// Three-requester writeback arbiter for the 8 x 16-bit register file: one-entry holding buffer
// per requester, registered write port, busy scoreboard. Define RFWA_ROUND_ROBIN_EN for round-robin.
module regfile_write_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 hold,
  output logic                 RegWrite,
  output logic [AW-1:0]        WriteReg,
  output logic [DW-1:0]        WriteData,
  output logic [NREQ-1:0]      grant,
  output logic [(1<<AW)-1:0]   busy
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [NREQ-1:0] buf_valid_q;
  logic [AW-1:0]   buf_addr_q [NREQ];
  logic [DW-1:0]   buf_data_q [NREQ];

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] gnt_now;
  logic [IdxW-1:0] gnt_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            found;

  assign cand      = buf_valid_q & {NREQ{~hold}};
  assign req_ready = {NREQ{~rst}} & (~buf_valid_q | gnt_now);

`ifdef RFWA_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Search from the start index, wrapping modulo NREQ; first candidate found wins.
  always_comb begin
    int unsigned start;
    int unsigned j;
    gnt_now  = '0;
    gnt_idx  = '0;
    win_addr = '0;
    win_data = '0;
    found    = 1'b0;
`ifdef RFWA_ROUND_ROBIN_EN
    start    = 32'(ptr_q);
`else
    start    = 0;
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = start + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && cand[j]) begin
        found      = 1'b1;
        gnt_now[j] = 1'b1;
        gnt_idx    = IdxW'(j);
        win_addr   = buf_addr_q[j];
        win_data   = buf_data_q[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        // A refill takes priority so a granted buffer can be reloaded on the same edge.
        if (req_valid[i] && req_ready[i]) begin
          buf_valid_q[i] <= 1'b1;
          buf_addr_q[i]  <= req_addr[i*AW +: AW];
          buf_data_q[i]  <= req_data[i*DW +: DW];
        end else if (gnt_now[i]) begin
          buf_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      grant     <= '0;
    end else if (found) begin
      RegWrite  <= 1'b1;
      WriteReg  <= win_addr;
      WriteData <= win_data;
      grant     <= gnt_now;
    end else begin
      RegWrite  <= 1'b0;
      grant     <= '0;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (buf_valid_q[i]) busy[buf_addr_q[i]] = 1'b1;
    end
    if (RegWrite) busy[WriteReg] = 1'b1;
  end

endmodule
